// File: rtl/seg_scan_driver_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg_scan_driver_if
//
// Frame-buffer load port between the pattern/animation controller (master)
// and the seven-segment scan driver (slave).
//
// Handshake: there is no ready signal. The slave accepts a write on every
// cycle in which wr_en is high, and it registers a commit request on every
// cycle in which commit is high. The master therefore never stalls and may
// issue back-to-back writes.
//
// Signals:
//   wr_en    write strobe for the shadow frame buffer
//   wr_addr  digit index, 0 = leftmost, 3 = rightmost
//   wr_data  segment pattern, bit7..0 = a,b,c,d,e,f,g,dp, 1 = lit
//   commit   single-cycle request to publish the shadow buffer
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output commit
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data,
        input commit
    );
endinterface

// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed scan driver for a 4-digit common-anode seven-segment
// display. A shadow frame buffer is written through wr_bus and copied into
// the active buffer in one step at the frame boundary following a commit.
// Each digit slot starts with BLANK_CYC clocks of all-digits-off to suppress
// ghosting, then drives the digit gated by a free-running 16-step PWM.
//
// Parameters:
//   SCAN_DIV   clocks per digit slot (>= BLANK_CYC + 16)
//   BLANK_CYC  blanking clocks at the start of each slot (>= 1)
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   wr_bus          slave side of the frame-buffer load port
//   brightness      PWM level, 0 = dark, 15 = full on
//   an              digit enables, active-low (one-hot-low or all ones)
//   seg             segment drive, active-high, same bit order as wr_data
//   commit_pending  high from the cycle after commit until the swap completes
//   frame_start     one-cycle pulse on the first output cycle of a digit-0 slot
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                     clk,
    input  logic                     reset,
    seg_scan_driver_if.slave         wr_bus,
    input  logic [3:0]               brightness,
    output logic [3:0]               an,
    output logic [7:0]               seg,
    output logic                     commit_pending,
    output logic                     frame_start
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);

    // Scan counters
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    pwm_q, pwm_d;

    // Frame buffers and commit state
    logic [7:0]    shadow_q [4];
    logic [7:0]    shadow_d [4];
    logic [7:0]    active_q [4];
    logic [7:0]    active_d [4];
    logic          pending_q, pending_d;

    // Registered outputs
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fs_q, fs_d;

    logic          slot_wrap;
    logic          swap;
    logic          blanking;
    logic          lit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q    <= '0;
            digit_q   <= '0;
            pwm_q     <= '0;
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            pending_q <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= '0;
            fs_q      <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            digit_q   <= digit_d;
            pwm_q     <= pwm_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            fs_q      <= fs_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: counters, buffers, commit tracking
    // -------------------------------------------------------------------------
    always_comb begin
        slot_wrap = (slot_q == SLOT_LAST);
        // Last cycle of the digit-3 slot: the only point where the active
        // buffer may change, so a frame is never shown half old, half new.
        swap      = slot_wrap && (digit_q == 2'd3);

        slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
        digit_d   = slot_wrap ? digit_q + 2'd1 : digit_q;
        pwm_d     = pwm_q + 4'd1;

        // The swap copies pre-edge shadow contents, so a write landing in the
        // swap cycle only reaches the shadow and waits for the next commit.
        active_d = active_q;
        if (swap && pending_q) begin
            active_d = shadow_q;
        end

        shadow_d = shadow_q;
        if (wr_bus.wr_en) begin
            shadow_d[wr_bus.wr_addr] = wr_bus.wr_data;
        end

        // A commit arriving in the swap cycle overrides the clear, leaving the
        // request armed for the following boundary.
        pending_d = pending_q;
        if (swap) begin
            pending_d = 1'b0;
        end
        if (wr_bus.commit) begin
            pending_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: decoded from the current counter state, registered above
    // -------------------------------------------------------------------------
    always_comb begin
        blanking = (slot_q < BLANK_END);
        lit      = (brightness == 4'hF) || (pwm_q < brightness);

        an_d  = 4'hF;
        seg_d = '0;
        if (!blanking && lit) begin
            // Digit 0 is the leftmost position, driven by an[3].
            an_d[2'd3 - digit_q] = 1'b0;
            seg_d                = active_q[digit_q];
        end

        fs_d = (slot_q == '0) && (digit_q == 2'd0);
    end

    assign an             = an_q;
    assign seg            = seg_q;
    assign commit_pending = pending_q;
    assign frame_start    = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Bench for seg_scan_driver with SCAN_DIV = 40, BLANK_CYC = 4 (160-cycle
// frame). A reference model derives every output from the number of cycles
// elapsed since reset release; a compare process checks it each cycle, and
// directed scenarios pin literal values taken from the display behaviour.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int SD = 40;
    localparam int BC = 4;
    localparam int FR = 4 * SD;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] brightness;
    logic [3:0] an;
    logic [7:0] seg;
    logic       commit_pending;
    logic       frame_start;

    always #5 clk = ~clk;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_bus         (bus.slave),
        .brightness     (brightness),
        .an             (an),
        .seg            (seg),
        .commit_pending (commit_pending),
        .frame_start    (frame_start)
    );

    // -------------------------------------------------------------------------
    // Scoreboard counters and check helper
    // -------------------------------------------------------------------------
    int n_assert = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: position in the frame is just the cycle count since
    // reset release; slot, digit and PWM phase follow by division/modulo.
    // -------------------------------------------------------------------------
    int         m_k;
    logic [7:0] m_shadow [4];
    logic [7:0] m_active [4];
    bit         m_pending;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_fs;

    function automatic bit model_lit(int k, logic [3:0] br);
        int slot = k % SD;
        int pwm  = k % 16;
        return (slot >= BC) && ((br == 4'd15) || (pwm < int'(br)));
    endfunction

    function automatic logic [3:0] model_an(int k, logic [3:0] br);
        logic [3:0] onehot;
        int dig = (k / SD) % 4;
        onehot = 4'b1000 >> dig;
        return model_lit(k, br) ? ~onehot : 4'hF;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_k       <= 0;
            m_pending <= 1'b0;
            m_shadow  <= '{default: '0};
            m_active  <= '{default: '0};
            e_an      <= 4'hF;
            e_seg     <= '0;
            e_fs      <= 1'b0;
        end else begin
            e_an  <= model_an(m_k, brightness);
            e_seg <= model_lit(m_k, brightness) ? m_active[(m_k / SD) % 4] : 8'h00;
            e_fs  <= ((m_k % FR) == 0);
            if (((m_k % FR) == FR - 1) && m_pending) begin
                m_active <= m_shadow;
            end
            if (bus.wr_en) begin
                m_shadow[bus.wr_addr] <= bus.wr_data;
            end
            if (bus.commit) begin
                m_pending <= 1'b1;
            end else if ((m_k % FR) == FR - 1) begin
                m_pending <= 1'b0;
            end
            m_k <= m_k + 1;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            check("model_an", an, e_an);
            check("model_seg", seg, e_seg);
            check("model_frame_start", frame_start, e_fs);
            check("model_commit_pending", commit_pending, m_pending);
        end
    end

    // commit_pending history: value in the previous two cycles
    logic cp_p1 = 1'b0;
    logic cp_p2 = 1'b0;
    always @(posedge clk) begin
        cp_p2 <= cp_p1;
        cp_p1 <= commit_pending;
    end

    // -------------------------------------------------------------------------
    // Driver tasks (all called at a negedge, return at a negedge)
    // -------------------------------------------------------------------------
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_assert++;
        n_fail++;
        $display("FAIL frame_start_timeout: got no pulse in 400 cycles, expected one at %0t", $time);
    endtask

    // Frame capture: index i is output cycle i of the frame (0 = frame_start)
    logic [3:0] cap_an  [FR];
    logic [7:0] cap_seg [FR];
    logic       fs_cp1;
    logic       fs_cp2;
    bit         cap_ok;

    task automatic capture_frame();
        wait_frame(cap_ok);
        if (!cap_ok) return;
        fs_cp1     = cp_p1;
        fs_cp2     = cp_p2;
        cap_an[0]  = an;
        cap_seg[0] = seg;
        for (int i = 1; i < FR; i++) begin
            @(negedge clk);
            cap_an[i]  = an;
            cap_seg[i] = seg;
        end
    endtask

    // First lit sample of each slot must show that digit with the expected
    // pattern; at full brightness the slot has exactly BC blank cycles and
    // SD-BC lit cycles.
    task automatic check_slots(string tag, logic [31:0] exp_vals, bit full_on);
        logic [3:0] exp_an;
        logic [3:0] onehot;
        int         idx;
        int         nb;
        int         nl;
        for (int s = 0; s < 4; s++) begin
            onehot = 4'b1000 >> s;
            exp_an = ~onehot;
            idx    = s * SD + BC;
            check({tag, "_an"}, cap_an[idx], exp_an);
            check({tag, "_seg"}, cap_seg[idx], exp_vals[31 - 8 * s -: 8]);
            if (full_on) begin
                nb = 0;
                for (int j = 0; j < SD; j++) begin
                    if (cap_an[s * SD + j] != 4'hF) break;
                    nb++;
                end
                check({tag, "_blank_cycles"}, nb, BC);
                nl = 0;
                for (int j = BC; j < SD; j++) begin
                    if (cap_an[s * SD + j] == exp_an) nl++;
                end
                check({tag, "_lit_cycles"}, nl, SD - BC);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int fs_times[$];
    int cnt;

    initial begin
        brightness  = 4'd15;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.commit  = 1'b0;

        // Reset held for 3 cycles
        @(negedge clk);
        check_en = 1'b1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 8'h00);
        check("rst_commit_pending", commit_pending, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // This cycle is cycle 1 after release; frame_start at 2, 162, 322
        for (int c = 2; c <= 330; c++) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_times.push_back(c);
        end
        check("fs_pulse_count", fs_times.size(), 3);
        if (fs_times.size() == 3) begin
            check("fs_first", fs_times[0], 2);
            check("fs_second", fs_times[1], 162);
            check("fs_third", fs_times[2], 322);
        end

        // Load and commit
        wr(2'd0, 8'hFC);
        wr(2'd1, 8'h60);
        wr(2'd2, 8'hDA);
        wr(2'd3, 8'hF2);
        pulse_commit();
        check("load_cp_rise", commit_pending, 1'b1);
        capture_frame();
        check_slots("load", 32'hFC60DAF2, 1'b1);

        // Atomicity: shadow overwritten mid-frame, display unchanged
        repeat (60) @(negedge clk);
        for (int a = 0; a < 4; a++) wr(2'(a), 8'h02);
        capture_frame();
        check_slots("atomic_f1", 32'hFC60DAF2, 1'b0);
        capture_frame();
        check_slots("atomic_f2", 32'hFC60DAF2, 1'b0);

        // Commit during the digit-1 slot
        wait_frame(cap_ok);
        repeat (45) @(negedge clk);
        pulse_commit();
        check("atomic_cp_rise", commit_pending, 1'b1);
        capture_frame();
        check("atomic_cp_in_swap", fs_cp2, 1'b1);
        check("atomic_cp_after_swap", fs_cp1, 1'b0);
        check_slots("atomic_new", 32'h02020202, 1'b1);

        // Swap-cycle collision: write + commit exactly in the swap cycle
        wait_frame(cap_ok);
        repeat (FR - 2) @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd3;
        bus.wr_data = 8'h66;
        bus.commit  = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        bus.commit  = 1'b0;
        check("collide_cp_set", commit_pending, 1'b1);
        capture_frame();
        check("collide_cp_stays", fs_cp1, 1'b1);
        check_slots("collide_old", 32'h02020202, 1'b0);
        capture_frame();
        check_slots("collide_new", 32'h02020266, 1'b0);

        // Brightness 0: every cycle dark
        brightness = 4'd0;
        capture_frame();
        cnt = 0;
        for (int i = 0; i < FR; i++) if (cap_an[i] != 4'hF) cnt++;
        check("bright0_driven_cycles", cnt, 0);

        // Brightness 8: half of each 16-cycle window inside the lit part
        brightness = 4'd8;
        capture_frame();
        for (int s = 0; s < 4; s++) begin
            cnt = 0;
            for (int j = BC; j < BC + 32; j++) if (cap_an[s * SD + j] != 4'hF) cnt++;
            check("bright8_driven_of_32", cnt, 16);
        end

        // Brightness 15 again
        brightness = 4'd15;
        capture_frame();
        check_slots("bright15", 32'h02020266, 1'b1);

        // Randomised traffic, checked by the model every cycle
        for (int i = 0; i < 4 * FR; i++) begin
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 2'($urandom_range(0, 3));
            bus.wr_data = 8'($urandom_range(0, 255));
            bus.commit  = ($urandom_range(0, 59) == 0);
            if ((i % 37) == 0) brightness = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;

        // Reset mid-operation during the digit-2 slot with a pending commit
        brightness = 4'd15;
        for (int a = 0; a < 4; a++) wr(2'(a), 8'hA5);
        wait_frame(cap_ok);
        repeat (2 * SD + 10) @(negedge clk);
        pulse_commit();
        check("midrst_cp_before", commit_pending, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_an", an, 4'hF);
        check("midrst_commit_pending", commit_pending, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        capture_frame();
        cnt = 0;
        for (int i = 0; i < FR; i++) if (cap_seg[i] != 8'h00) cnt++;
        check("midrst_seg_nonzero_cycles", cnt, 0);

        // Commit after reset must publish the cleared shadow, not the old A5s
        pulse_commit();
        capture_frame();
        check_slots("midrst_shadow_cleared", 32'h00000000, 1'b0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish before %0t", $time);
        $fatal(1, "time limit reached");
    end

endmodule
